serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : serial_subtractor                                                |
// | Desc    : Bit-serial WIDTH-bit subtractor, LSB first, registered borrow.   |
// |           Optional SERIAL_SUBTRACTOR_OVERFLOW_EN adds a signed overflow.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  output logic             borrow_out,
  output logic             overflow
`else
  output logic             borrow_out
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_shift = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  assign w_a        = r_a[0];
  assign w_b        = r_b[0];
  assign w_d        = w_a ^ w_b ^ r_br;
  assign w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  // Result fills from the MSB so the first (LSB) bit lands in bit 0 after WIDTH shifts.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_a     <= minuend;
            r_b     <= subtrahend;
            r_br    <= borrow_in;
            r_cnt   <= '0;
            r_state <= c_shift;
          end
        end
        c_shift: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff  <= w_res_next;
            r_bout  <= w_br_next;
            r_state <= c_done;
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  // Operand MSBs are shifted out of r_a/r_b, so keep a copy for the overflow test.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == c_idle && start) begin
        r_a_msb <= minuend[WIDTH-1];
        r_b_msb <= subtrahend[WIDTH-1];
      end
      if (r_state == c_shift && w_last) begin
        r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
      end
    end
  end

  assign overflow = r_ovf;
`endif

  assign ready      = (r_state == c_idle);
  assign busy       = (r_state == c_shift);
  assign done       = (r_state == c_done);
  assign difference = r_diff;
  assign borrow_out = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_serial_subtractor                                             |
// | Desc    : Directed self-checking bench for serial_subtractor (WIDTH=8).    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             borrow_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic             overflow;
`endif

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .borrow_in  (borrow_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .difference (difference),
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    .borrow_out (borrow_out),
    .overflow   (overflow)
`else
    .borrow_out (borrow_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation: accept, count edges to done, check results.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] exp_d, input logic exp_b,
                        input logic exp_ov);
    int n;
    @(negedge clk);
    start = 1'b1; minuend = a; subtrahend = b; borrow_in = bin;
    @(posedge clk); #1;
    start = 1'b0; minuend = ~a; subtrahend = ~b; borrow_in = ~bin;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, WIDTH);
    check({tag, "_diff"}, {24'd0, difference}, {24'd0, exp_d});
    check({tag, "_bout"}, {31'd0, borrow_out}, {31'd0, exp_b});
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ov});
`else
    if (exp_ov) n = n;
`endif
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, ready, done}, 32'd2);
  endtask

  initial begin
    int first_done;
    int second_done;
    int seen_done;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; minuend = '0; subtrahend = '0; borrow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {27'd0, ready, busy, done, borrow_out, 1'b0}, {27'd0, 5'b10000});
    check("rst_diff", {24'd0, difference}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("op35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    run_op("op00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("op10_10b", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("op00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("op80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("op05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    // start held high with operands changing every cycle after acceptance
    @(negedge clk);
    start = 1'b1; minuend = 8'hA0; subtrahend = 8'h0F; borrow_in = 1'b0;
    @(posedge clk); #1;
    first_done = -1; second_done = -1;
    for (int i = 1; i <= 18; i++) begin
      minuend = 8'(i * 37); subtrahend = 8'(i * 11); borrow_in = i[0];
      @(posedge clk); #1;
      if (done) begin
        if (first_done < 0) begin
          first_done = i;
          check("held_diff", {24'd0, difference}, 32'h91);
          check("held_bout", {31'd0, borrow_out}, 32'd0);
        end else if (second_done < 0) begin
          second_done = i;
        end
      end
    end
    start = 1'b0;
    check("held_first_done", first_done, WIDTH);
    check("held_period", second_done - first_done, WIDTH + 2);
    repeat (2) @(posedge clk);
    #1;
    check("held_back_idle", {31'd0, ready}, 32'd1);

    // reset mid-operation
    run_op("pre_rst", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; minuend = 8'hFF; subtrahend = 8'h01; borrow_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_state", {29'd0, ready, busy, done}, 32'b100);
    check("async_rst_diff", {23'd0, borrow_out, difference}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("no_done_after_abort", seen_done, 0);
    run_op("post_rst", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
